// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the MIPS program counter and sequences instruction
// fetch. Selects the next PC from the sequential, branch, jump, jump-register,
// exception and eret sources, runs the request/ready handshake with
// instruction memory, and freezes the PC while decode reports a hazard stall.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic        instr_valid,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic        advance;
  logic        trap_redirect;
  logic        jr_misaligned;
  logic [31:0] br_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;

  // Sequential address and the two PC-relative / pseudo-direct targets.
  // All adds wrap modulo 2^32, so 0xFFFFFFFC rolls over to 0.
  assign pc_plus4    = pc + 32'd4;
  assign br_target   = pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign jump_target = {pc_plus4[31:28], jump_index, 2'b00};

  // An instruction is consumed only when memory delivers and decode can take it.
  assign advance       = (state == FETCH) & imem_ready & ~stall;
  assign trap_redirect = exc | eret;

  // A misaligned jr only traps when jr is the winning redirect source.
  assign jr_misaligned = jr & (jr_target[1:0] != 2'b00) & ~exc & ~eret;

  // Fetched word is handed to decode this cycle unless a trap discards it.
  assign instr_valid = advance & ~exc & ~eret;

  // Priority mux for the next fetch address; highest-priority redirect wins.
  always_comb begin
    // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
    next_pc = pc_plus4;
    if (exc) begin
      next_pc = EXC_VECTOR;
    end else if (eret) begin
      next_pc = epc;
    end else if (jr) begin
      next_pc = jr_misaligned ? EXC_VECTOR : jr_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

  // Fetch FSM with registered PC, request and fault outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    // NOTE: asynchronous reset clears imem_req at once, aborting any fetch in flight.
    if (!Reset) begin
      pc          <= RESET_PC;
      state       <= BOOT;
      imem_req    <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      fetch_fault <= 1'b0;
      case (state)
        BOOT: begin
          // Redirects are ignored here; the first fetch is always RESET_PC.
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (trap_redirect) begin
            // Exception/eret override stall and ready; restart fetch at new pc.
            pc       <= next_pc;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else if (advance) begin
            pc          <= next_pc;
            fetch_fault <= jr_misaligned;
          end else if (imem_ready) begin
            // Data arrived but decode is stalled: park and refetch later.
            state    <= HOLD;
            imem_req <= 1'b0;
          end
        end

        HOLD: begin
          if (trap_redirect) begin
            pc       <= next_pc;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else if (!stall) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end

        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: table-driven bench for pc_fetch_sequencer. Each
// vector is one clock cycle; combinational outputs are compared mid-cycle and
// the expected post-edge registers are queued and popped after the edge.
module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        stall;
  logic        imem_ready;
  logic        br_taken;
  logic [15:0] br_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        exc;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        instr_valid;
  logic        fetch_fault;

  always #5 CLK = ~CLK;

  pc_fetch_sequencer dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .jump        (jump),
    .jump_index  (jump_index),
    .jr          (jr),
    .jr_target   (jr_target),
    .exc         (exc),
    .eret        (eret),
    .epc         (epc),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .imem_req    (imem_req),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault)
  );

  typedef struct {
    logic        stall;
    logic        ready;
    logic        br;
    logic [15:0] off;
    logic        jump;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jrt;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic        fault;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic b, input logic [15:0] o,
                              input logic j, input logic [25:0] ix, input logic jrr,
                              input logic [31:0] jt, input logic e, input logic er,
                              input logic [31:0] ep, input logic v, input logic [31:0] p,
                              input logic rq, input logic f);
    vec_t x;
    x.stall = s;   x.ready = r;  x.br = b;    x.off = o;
    x.jump = j;    x.idx = ix;   x.jr = jrr;  x.jrt = jt;
    x.exc = e;     x.eret = er;  x.epc = ep;
    x.exp_valid = v; x.exp_pc = p; x.exp_req = rq; x.exp_fault = f;
    return x;
  endfunction

  task automatic drive(input vec_t v);
    stall      = v.stall;
    imem_ready = v.ready;
    br_taken   = v.br;
    br_offset  = v.off;
    jump       = v.jump;
    jump_index = v.idx;
    jr         = v.jr;
    jr_target  = v.jrt;
    exc        = v.exc;
    eret       = v.eret;
    epc        = v.epc;
  endtask

  // One cycle: drive, check combinational outputs mid-cycle, check registers after the edge.
  task automatic apply(input vec_t v, input int n);
    exp_t e;
    drive(v);
    @(negedge CLK);
    check($sformatf("v%0d instr_valid", n), {31'b0, instr_valid}, {31'b0, v.exp_valid});
    check($sformatf("v%0d pc_plus4", n), pc_plus4, model_pc + 32'd4);
    e.pc = v.exp_pc; e.req = v.exp_req; e.fault = v.exp_fault;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL v%0d scoreboard: queue empty, expected 1 entry", n);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d pc", n), pc, e.pc);
      check($sformatf("v%0d imem_req", n), {31'b0, imem_req}, {31'b0, e.req});
      check($sformatf("v%0d fetch_fault", n), {31'b0, fetch_fault}, {31'b0, e.fault});
      model_pc = e.pc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    //        st rd br off       jp idx          jr jrt           ex er epc           v  pc             rq f
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_3000, 1, 0)); // BOOT
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_3004, 1, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_3008, 1, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_3008, 0, 0)); // -> HOLD
    tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_3008, 0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_3008, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_3008, 1, 0)); // HOLD -> FETCH
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_300C, 1, 0)); // refetch 3008
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_3010, 1, 0));
    tbl.push_back(mk(0, 1, 1, 16'hFFFC, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_3004, 1, 0)); // back branch
    tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 26'h0000C10, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_3040, 1, 0)); // jump
    tbl.push_back(mk(0, 0, 1, 16'h0010, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_3040, 1, 0)); // wait, br ignored
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 26'h5,       0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_3040, 1, 0)); // wait, jump ignored
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_3020, 0, 0, 32'h0,       1, 32'h0000_3020, 1, 0)); // jr aligned
    tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        1, 0, 32'h0,        0, 32'h0000_4180, 1, 0)); // exc over stall
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 1, 32'h0000_3024, 0, 32'h0000_3024, 1, 0)); // eret
    tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_3024, 0, 0)); // -> HOLD
    tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        1, 0, 32'h0,        0, 32'h0000_4180, 1, 0)); // exc in HOLD
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 1, 32'h0000_3024, 0, 32'h0000_3024, 1, 0)); // eret, not ready
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_3002, 0, 0, 32'h0,       1, 32'h0000_4180, 1, 1)); // misaligned jr
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_4180, 1, 0)); // fault drops
    tbl.push_back(mk(0, 1, 1, 16'h0100, 1, 26'h123,     1, 32'h0000_5000, 0, 0, 32'h0,       1, 32'h0000_5000, 1, 0)); // jr wins
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_0000, 1, 0)); // wrap
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_3002, 1, 1, 32'h0000_1234, 0, 32'h0000_4180, 1, 0)); // exc wins, no fault
    tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 26'h3FFFFFF, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0FFF_FFFC, 1, 0));
    tbl.push_back(mk(0, 1, 1, 16'h0004, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        1, 32'h1000_0010, 1, 0)); // fwd branch
    tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 26'h0000001, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1000_0004, 1, 0)); // keeps pc[31:28]
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        0, 32'h1000_0004, 1, 0)); // stall, not ready
    tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_3002, 0, 0, 32'h0,       0, 32'h1000_0004, 0, 0)); // jr ignored
    tbl.push_back(mk(0, 1, 1, 16'h0040, 0, 26'h0,       0, 32'h0,        0, 0, 32'h0,        0, 32'h1000_0004, 1, 0)); // HOLD exit

    // Reset state, with memory claiming ready.
    Reset = 1'b0;
    drive(mk(0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0));
    #12;
    check("reset pc", pc, 32'h0000_3000);
    check("reset pc_plus4", pc_plus4, 32'h0000_3004);
    check("reset imem_req", {31'b0, imem_req}, 32'h0);
    check("reset instr_valid", {31'b0, instr_valid}, 32'h0);
    check("reset fetch_fault", {31'b0, fetch_fault}, 32'h0);
    @(posedge CLK);
    #1;
    Reset    = 1'b1;
    model_pc = 32'h0000_3000;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Reset pulsed mid-fetch with memory not ready: effect is immediate.
    drive(mk(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0));
    #3;
    check("pre-reset pc", pc, 32'h1000_0004);
    Reset = 1'b0;
    #1;
    check("async reset pc", pc, 32'h0000_3000);
    check("async reset imem_req", {31'b0, imem_req}, 32'h0);
    check("async reset instr_valid", {31'b0, instr_valid}, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    Reset    = 1'b1;
    model_pc = 32'h0000_3000;

    // eret during BOOT is ignored; fetch resumes from RESET_PC.
    apply(mk(0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 1, 32'h0000_1234, 0, 32'h0000_3000, 1, 0), 100);
    apply(mk(0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0,         1, 32'h0000_3004, 1, 0), 101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Owns the program counter register and sequences instruction fetch for the MIPS core.
- Computes the next PC from sequential, branch, jump, jump-register, exception and eret sources.
- Runs a request/ready handshake with instruction memory.
- Freezes the PC on decode-stage hazard stalls.
- Replaces the standalone PC register plus external next-PC mux.

Parameters:
RESET_PC, 32'h00003000, PC value loaded on reset.
EXC_VECTOR, 32'h00004180, exception handler entry address.

Ports:
CLK  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-low reset
stall  input  1  decode hazard; holds PC, blocks advance
imem_ready  input  1  instruction memory has data for current pc
br_taken  input  1  conditional branch resolved taken
br_offset  input  16  branch immediate (word offset)
jump  input  1  J/JAL redirect
jump_index  input  26  J-type target index
jr  input  1  JR/JALR redirect
jr_target  input  32  register target for jr
exc  input  1  exception request
eret  input  1  return from exception
epc  input  32  return address for eret
pc  output  32  current fetch address
pc_plus4  output  32  pc + 4 (mod 2^32), combinational
imem_req  output  1  fetch request to instruction memory
instr_valid  output  1  fetched instruction accepted this cycle
fetch_fault  output  1  one-cycle pulse: misaligned jr target trapped

Behaviour:
Reset:
- Reset low: asynchronously set pc=RESET_PC, state=BOOT, fetch_fault=0.
- While Reset is low: imem_req=0 and instr_valid=0.
- Reset asserted mid-fetch aborts the fetch immediately.

FSM:
- BOOT: imem_req=0. Next cycle goes to FETCH; pc unchanged.
- FETCH: imem_req=1.
  - advance = imem_ready & !stall.
  - On advance: pc <= next_pc; stay in FETCH.
  - imem_ready & stall: go to HOLD, pc unchanged.
  - !imem_ready: stay in FETCH, pc unchanged. Wait is unbounded.
- HOLD: imem_req=0, pc frozen. When stall=0, go to FETCH and refetch the same pc.

Outputs:
- instr_valid = (state==FETCH) & imem_ready & !stall & !exc & !eret. Combinational, zero latency.

next_pc priority, applied only on advance unless noted:
1. exc: EXC_VECTOR.
2. eret: epc.
3. jr: jr_target.
4. jump: {pc_plus4[31:28], jump_index, 2'b00}.
5. br_taken: pc_plus4 + (sign_extend(br_offset) << 2).
6. Otherwise: pc_plus4.

exc / eret:
- Honoured in FETCH and HOLD regardless of stall or imem_ready.
- Load pc, abort any outstanding request, go to FETCH next cycle.
- Ignored in BOOT.

Misaligned jr target (jr_target[1:0] != 0, on advance):
- pc <= EXC_VECTOR.
- fetch_fault=1 for the next cycle only.

Arithmetic:
- All adds are 32-bit modulo 2^32; no overflow flag.
- pc=32'hFFFFFFFC advances to 32'h00000000.

Simultaneous and boundary events:
- Multiple redirects in one cycle: highest priority wins; the others are discarded.
- Redirect inputs outside an advance cycle, other than exc/eret: ignored.
- Stall alone never changes pc. exc still overrides stall.
- pc[1:0] is always 0 after reset, except via an unaligned epc, which is passed through unchecked.

Test Plan:
- Reset low, then release; imem_ready=1, no stall -> pc 0x3000, BOOT 1 cycle, then 0x3000, 0x3004, 0x3008; instr_valid high each FETCH cycle.
- At pc=0x3010 assert br_taken with br_offset=16'hFFFC -> pc=0x3004. Then jump with jump_index=26'h0000C10 -> pc=0x3040.
- stall high for 3 cycles with imem_ready=1 at pc=0x3008 -> HOLD, imem_req=0, pc stays 0x3008; after release, refetch 0x3008, then 0x300C.
- exc during a stall at pc=0x3020 -> pc=0x4180 next cycle, state FETCH. eret with epc=0x3024 -> pc=0x3024.
- jr with jr_target=0x3002 -> pc=0x4180 and fetch_fault pulses one cycle. Same cycle jr+jump+br_taken with aligned jr_target=0x5000 -> pc=0x5000.
- pc forced to 0xFFFFFFFC via eret, then advance -> pc=0x00000000. Reset pulsed low mid-fetch with imem_ready=0 -> pc=0x3000 immediately, imem_req drops asynchronously.
